// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_queue_pkg;
  localparam int               XLEN         = 32;
  localparam logic [XLEN-1:0]  NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0]  RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry presented from registered storage.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       head_valid,
  output logic [W-1:0]               head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  // Pointer/count update; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_en    = push & ~flush;
    rd_en    = pop & ~flush & (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;  // natural wrap, DEPTH is 2^n
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

  // The issue credit scheme must never let a response land in a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && count_q == CW'(DEPTH)));
endmodule

// File: rtl/fetch_queue.sv
// IF front end: issues BRAM reads under a credit limit and queues {pc,instr}
// for decode; an EX redirect flushes the queue and the in-flight read.
module fetch_queue #(
  parameter int              XLEN     = fetch_queue_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = fetch_queue_pkg::RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_en,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_instr,
  output logic [XLEN-1:0]            id_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);
  import fetch_queue_pkg::*;

  localparam int              CW  = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic              pending_q, pending_d;
  logic [CW-1:0]     count;
  logic [CW:0]       inflight;
  logic              credit, issue, push, pop, head_vld;
  logic [2*XLEN-1:0] head;

  // Issue decision and next fetch state. Credits use registered count only,
  // so a pop this cycle frees a slot one cycle later. Issue is held off while
  // reset is asserted so imem_en reads 0 during reset.
  always_comb begin
    inflight   = {1'b0, count} + {{CW{1'b0}}, pending_q};
    credit     = inflight < (CW+1)'(DEPTH);
    imem_addr  = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : fetch_pc_q;
    issue      = rst_n & (redirect_valid | credit);
    imem_en    = issue;
    fetch_pc_d = issue ? imem_addr + XLEN'(4) : fetch_pc_q;
    resp_pc_d  = issue ? imem_addr : resp_pc_q;
    pending_d  = issue;
    // A redirect kills the response of the previous cycle's read and any pop.
    push       = pending_q & ~redirect_valid;
    pop        = head_vld & id_ready & ~redirect_valid;
  end

  // Fetch PC and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      pending_q  <= pending_d;
    end
  end

  fetch_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .wdata     ({resp_pc_q, imem_rdata}),
    .count     (count),
    .head_valid(head_vld),
    .head_data (head)
  );

  // Present NOP/0 to decode whenever the queue is empty.
  always_comb begin
    id_valid = head_vld;
    id_instr = head_vld ? head[XLEN-1:0]      : NOP;
    id_pc    = head_vld ? head[2*XLEN-1:XLEN] : '0;
    q_count  = count;
  end
endmodule
